// File: rtl/bus_debug_pkg.sv
// Shared opcodes, response bytes, FSM encoding and request struct for bus_debug_master.
package bus_debug_pkg;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h3F;
  localparam logic [7:0] RSP_TMO  = 8'h54;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_debug_master_watchdog.sv
// Bus stall watchdog: counts BUS cycles without mem_ready, flags when TIMEOUT_CYCLES is reached.
module bus_debug_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic in_bus,
  input  logic mem_ready,
  output logic timeout
);

  logic [15:0] cnt_q, cnt_d;

  // Held at zero outside BUS, so every BUS entry starts from a cleared count.
  always_comb begin
    cnt_d = '0;
    if (in_bus) cnt_d = mem_ready ? cnt_q : cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Fires on the cycle whose increment reaches the limit; a same-cycle mem_ready wins.
  assign timeout = in_bus && !mem_ready && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_debug_master.sv
// Byte-stream debug initiator for the native valid/ready memory bus.
// Optional bus watchdog enabled by defining BUS_DEBUG_WATCHDOG_EN.
module bus_debug_master
  import bus_debug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  cnt_q, cnt_d;
  bus_req_t    req_q, req_d;
  logic [31:0] rsp_q, rsp_d;
  logic [1:0]  rsp_last_q, rsp_last_d;
  logic        rx_hs, tx_hs, in_bus, wd_timeout;

  assign in_bus = (state_q == ST_BUS);

`ifdef BUS_DEBUG_WATCHDOG_EN
  bus_debug_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk       (clk),
    .resetn    (resetn),
    .in_bus    (in_bus),
    .mem_ready (mem_ready),
    .timeout   (wd_timeout)
  );
`else
  assign wd_timeout = 1'b0;
`endif

  assign rx_ready  = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign tx_valid  = (state_q == ST_RESP);
  assign tx_data   = tx_valid ? rsp_q[{cnt_q, 3'b000} +: 8] : 8'h00;
  assign mem_valid = in_bus;
  assign mem_instr = 1'b0;
  assign mem_addr  = {req_q.addr[31:2], 2'b00};
  assign mem_wdata = req_q.wdata;
  assign mem_wstrb = is_wr_q ? 4'hF : 4'h0;

  assign rx_hs = rx_valid && rx_ready;
  assign tx_hs = tx_valid && tx_ready;

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    rsp_d      = rsp_q;
    rsp_last_d = rsp_last_q;
    case (state_q)
      ST_IDLE: if (rx_hs) begin
        cnt_d = '0;
        if (rx_data == OP_READ) begin
          is_wr_d = 1'b0;
          state_d = ST_ADDR;
        end else if (rx_data == OP_WRITE) begin
          is_wr_d = 1'b1;
          state_d = ST_ADDR;
        end else begin
          rsp_d      = {24'h0, RSP_ERR};
          rsp_last_d = 2'd0;
          state_d    = ST_RESP;
        end
      end
      // Little-endian bytes shift in from the top; after four the first byte sits in [7:0].
      ST_ADDR: if (rx_hs) begin
        req_d.addr = {rx_data, req_q.addr[31:8]};
        cnt_d      = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = is_wr_q ? ST_DATA : ST_BUS;
      end
      ST_DATA: if (rx_hs) begin
        req_d.wdata = {rx_data, req_q.wdata[31:8]};
        cnt_d       = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = ST_BUS;
      end
      ST_BUS: if (mem_ready) begin
        cnt_d      = '0;
        state_d    = ST_RESP;
        rsp_d      = is_wr_q ? {24'h0, RSP_ACK} : mem_rdata;
        rsp_last_d = is_wr_q ? 2'd0 : 2'd3;
      end else if (wd_timeout) begin
        cnt_d      = '0;
        state_d    = ST_RESP;
        rsp_d      = {24'h0, RSP_TMO};
        rsp_last_d = 2'd0;
      end
      ST_RESP: if (tx_hs) begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == rsp_last_q) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      is_wr_q    <= 1'b0;
      cnt_q      <= '0;
      req_q      <= '0;
      rsp_q      <= '0;
      rsp_last_q <= '0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      rsp_q      <= rsp_d;
      rsp_last_q <= rsp_last_d;
    end
  end

endmodule

// File: tb/tb_bus_debug_master.sv
// Randomized bench for bus_debug_master with a command-level reference model.
module tb_bus_debug_master;
  localparam int TMO = 16;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        rx_valid = 1'b0, tx_ready = 1'b0, mem_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] mem_rdata = 32'h0;
  logic        rx_ready, tx_valid, mem_valid, mem_instr;
  logic [7:0]  tx_data;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  bus_debug_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: command parser, pending bus transaction, expected tx bytes.
  logic [7:0]  cmd_q[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic [31:0] log_addr[$], log_wdata[$];
  logic [3:0]  log_wstrb[$];
  bit          bus_act = 0, e_rd = 0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic [3:0]  e_wstrb = '0;
  int          wait_cnt = 0, mv_cycles = 0;

  always @(negedge clk) begin
    bit exp_rdy;
    if (!resetn) begin
      chk("rst_rx_ready", rx_ready, 1);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_wstrb", mem_wstrb, 0);
      cmd_q.delete(); exp_tx.delete();
      bus_act = 0;
    end else begin
      exp_rdy = !bus_act && exp_tx.size() == 0;
      chk("rx_ready", rx_ready, exp_rdy);
      chk("mem_valid", mem_valid, bus_act);
      chk("tx_valid", tx_valid, exp_tx.size() != 0);
      chk("mem_instr", mem_instr, 0);
      if (mem_valid) mv_cycles++;
      if (bus_act) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wstrb", mem_wstrb, e_wstrb);
        if (!e_rd) chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (exp_tx.size() != 0) begin
        chk("tx_data", tx_data, exp_tx[0]);
        if (tx_ready) begin
          tx_log.push_back(tx_data);
          void'(exp_tx.pop_front());
        end
      end
      if (bus_act) begin
        if (mem_ready) begin
          bus_act = 0;
          log_addr.push_back(mem_addr); log_wdata.push_back(mem_wdata); log_wstrb.push_back(mem_wstrb);
          if (e_rd) for (int i = 0; i < 4; i++) exp_tx.push_back(mem_rdata[8*i +: 8]);
          else exp_tx.push_back(8'h4B);
        end else begin
          wait_cnt++;
`ifdef BUS_DEBUG_WATCHDOG_EN
          if (wait_cnt == TMO) begin
            bus_act = 0;
            exp_tx.push_back(8'h54);
          end
`endif
        end
      end
      if (exp_rdy && rx_valid) begin
        cmd_q.push_back(rx_data);
        if (cmd_q[0] != 8'h52 && cmd_q[0] != 8'h57) begin
          exp_tx.push_back(8'h3F);
          cmd_q.delete();
        end else if ((cmd_q[0] == 8'h52 && cmd_q.size() == 5) || cmd_q.size() == 9) begin
          e_rd    = (cmd_q[0] == 8'h52);
          e_addr  = {cmd_q[4], cmd_q[3], cmd_q[2], cmd_q[1]} & ~32'h3;
          e_wstrb = e_rd ? 4'h0 : 4'hF;
          if (!e_rd) e_wdata = {cmd_q[8], cmd_q[7], cmd_q[6], cmd_q[5]};
          bus_act  = 1;
          wait_cnt = 0;
          cmd_q.delete();
        end
      end
    end
  end

  // Responder and tx sink, driven just after each rising edge.
  int          rdy_delay = 0, bus_n = 0;
  bit          tx_stall = 0, use_force = 0;
  logic [31:0] rdata_force = 32'h12345678;

  initial forever begin
    @(posedge clk); #1;
    bus_n     = mem_valid ? bus_n + 1 : 0;
    mem_ready = mem_valid ? (bus_n - 1 >= rdy_delay) : ($urandom % 8 == 0);
    mem_rdata = use_force ? rdata_force : $urandom;
    tx_ready  = tx_stall ? 1'b0 : ($urandom % 4 != 0);
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit got;
    int n;
    n = 0;
    rx_valid = 1'b1; rx_data = b;
    do begin
      @(negedge clk); got = rx_ready;
      @(posedge clk); #1; n++;
    end while (!got && n < 500);
    if (!got) chk("rx_accept_timeout", 0, 1);
    rx_valid = 1'b0; rx_data = 8'($urandom);
    if (gaps && $urandom % 4 == 0) repeat ($urandom % 3) begin @(posedge clk); #1; end
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d, input bit gaps);
    send_byte(op, gaps);
    if (op == 8'h52 || op == 8'h57)
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], gaps);
    if (op == 8'h57)
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], gaps);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus_act || exp_tx.size() != 0 || cmd_q.size() != 0) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    tx_log.delete(); log_addr.delete(); log_wdata.delete(); log_wstrb.delete();
    mv_cycles = 0;
  endtask

  task automatic chk_rd_bytes(input string name);
    logic [31:0] got;
    chk({name, "_len"}, tx_log.size(), 4);
    got = '0;
    for (int i = 0; i < 4 && i < tx_log.size(); i++) got[8*i +: 8] = tx_log[i];
    chk(name, got, 32'h12345678);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Write: mem_ready on third BUS cycle
    clear_logs(); rdy_delay = 2;
    send_cmd(8'h57, 32'h00000008, 32'hDEADBEEF, 0);
    wait_idle();
    chk("wr_tx_len", tx_log.size(), 1);
    if (tx_log.size() > 0) chk("wr_tx_ack", tx_log[0], 8'h4B);
    chk("wr_txn_cnt", log_addr.size(), 1);
    if (log_addr.size() > 0) begin
      chk("wr_addr", log_addr[0], 32'h00000008);
      chk("wr_wdata", log_wdata[0], 32'hDEADBEEF);
      chk("wr_wstrb", log_wstrb[0], 4'hF);
    end
    chk("wr_bus_cycles", mv_cycles, 3);

    // Read with fixed read data
    clear_logs(); rdy_delay = 1; use_force = 1;
    send_cmd(8'h52, 32'h02000004, 32'h0, 0);
    wait_idle();
    chk_rd_bytes("rd_bytes");
    if (log_addr.size() > 0) begin
      chk("rd_addr", log_addr[0], 32'h02000004);
      chk("rd_wstrb", log_wstrb[0], 4'h0);
    end
    chk("rd_bus_cycles", mv_cycles, 2);

    // Bad opcode, then a normal read
    clear_logs();
    send_cmd(8'h41, 32'h0, 32'h0, 0);
    wait_idle();
    chk("bad_tx_len", tx_log.size(), 1);
    if (tx_log.size() > 0) chk("bad_tx_err", tx_log[0], 8'h3F);
    chk("bad_no_bus", mv_cycles, 0);
    clear_logs();
    send_cmd(8'h52, 32'h00000013, 32'h0, 0);
    wait_idle();
    chk_rd_bytes("after_bad_rd");
    if (log_addr.size() > 0) chk("after_bad_addr", log_addr[0], 32'h00000010);

    // Backpressure on the read response
    clear_logs(); tx_stall = 1;
    send_cmd(8'h52, 32'h00000100, 32'h0, 0);
    for (int n = 0; n < 50 && !tx_valid; n++) begin @(posedge clk); #1; end
    chk("bp_tx_valid", tx_valid, 1);
    repeat (10) begin @(posedge clk); #1; end
    tx_stall = 0;
    wait_idle();
    chk_rd_bytes("bp_bytes");
    use_force = 0;

    // Reset while the bus request is outstanding
    clear_logs(); rdy_delay = 100000;
    send_cmd(8'h52, 32'h00000200, 32'h0, 0);
    chk("mid_bus_valid", mem_valid, 1);
    @(posedge clk); #3 resetn = 1'b0;
    #1 chk("async_drop", mem_valid, 0);
    @(posedge clk); #1 resetn = 1'b1;
    rdy_delay = 0;
    repeat (5) begin @(posedge clk); #1; end
    chk("post_rst_no_tx", tx_log.size(), 0);
    chk("post_rst_rx_ready", rx_ready, 1);

`ifdef BUS_DEBUG_WATCHDOG_EN
    clear_logs(); rdy_delay = 100000;
    send_cmd(8'h52, 32'h00000300, 32'h0, 0);
    wait_idle();
    chk("wd_tx_len", tx_log.size(), 1);
    if (tx_log.size() > 0) chk("wd_tx_tmo", tx_log[0], 8'h54);
    chk("wd_bus_cycles", mv_cycles, TMO);
    rdy_delay = 0;
`endif

    // Randomized command stream
    for (int k = 0; k < 60; k++) begin
      int sel;
      logic [7:0] op;
      sel = $urandom % 10;
      if (sel < 4)      op = 8'h52;
      else if (sel < 8) op = 8'h57;
      else begin
        op = 8'($urandom);
        if (op == 8'h52 || op == 8'h57) op = 8'h00;
      end
      rdy_delay = $urandom % 5;
      send_cmd(op, $urandom, $urandom, 1);
      if ($urandom % 3 == 0) wait_idle();
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
